// File: rtl/cond_logic_if.sv
// ALU flag / condition interface between decoder-datapath and cond_logic.
// master drives instruction-side controls; slave returns gated strobes.
interface cond_logic_if;
   logic       En;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       RegW;
   logic       MemW;
   logic       NoWrite;
   logic       PCSrc;
   logic       RegWrite;
   logic       MemWrite;
   logic       CondEx;
   logic [3:0] Flags;

   modport master (
      output En, Cond, ALUFlags, FlagW,
      output PCS, RegW, MemW, NoWrite,
      input  PCSrc, RegWrite, MemWrite,
      input  CondEx, Flags
   );

   modport slave (
      input  En, Cond, ALUFlags, FlagW,
      input  PCS, RegW, MemW, NoWrite,
      output PCSrc, RegWrite, MemWrite,
      output CondEx, Flags
   );
endinterface

// File: rtl/cond_logic.sv
// NZCV flag register, condition evaluation and write-strobe gating.
// Flag bit order is {N,Z,C,V} throughout.
module cond_logic #(
   parameter logic [3:0] FLAG_RESET = 4'b0000
) (
   input  logic        clk,
   input  logic        reset_n,
   cond_logic_if.slave bus
);

   logic [3:0] flags_q;
   logic [3:0] flags_d;
   logic [1:0] flag_write;
   logic       cond_ex;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags_q;

   always_comb begin
      cond_ex = 1'b1;
      unique case (bus.Cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~c | z;
         4'b1010: cond_ex = n ~^ v;
         4'b1011: cond_ex = n ^ v;
         4'b1100: cond_ex = ~z & (n ~^ v);
         4'b1101: cond_ex = z | (n ^ v);
         default: cond_ex = 1'b1;
      endcase
   end

   assign flag_write = bus.FlagW & {2{cond_ex}};

   always_comb begin
      flags_d = flags_q;
      if (flag_write[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (flag_write[0]) flags_d[1:0] = bus.ALUFlags[1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         flags_q <= FLAG_RESET;
      else if (bus.En)
         flags_q <= flags_d;
   end

   // Strobes are held low for the whole reset interval, not just at edges.
   assign bus.PCSrc    = reset_n & bus.PCS & cond_ex;
   assign bus.RegWrite = reset_n & bus.RegW & cond_ex & ~bus.NoWrite;
   assign bus.MemWrite = reset_n & bus.MemW & cond_ex;
   assign bus.CondEx   = cond_ex;
   assign bus.Flags    = flags_q;

endmodule
